mux8_sel_sequencer: RTL and testbench



---
 rtl/mux8_sel_sequencer_if.sv | 22 ++
 rtl/mux8_sel_sequencer.sv | 92 +++++++++
 tb/tb_mux8_sel_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mux8_sel_sequencer_if.sv
// Word-in / serial-select-out bundle between the word source, the sequencer and the 8:1 mux.
interface mux8_sel_sequencer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] mux_in;
    logic [2:0] mux_sel;
    logic       bit_valid;
    logic       bit_first;
    logic       bit_last;
    logic       done;

    modport master (
        output in_valid, in_data,
        input  in_ready, mux_in, mux_sel, bit_valid, bit_first, bit_last, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mux_in, mux_sel, bit_valid, bit_first, bit_last, done
    );
endinterface

// File: rtl/mux8_sel_sequencer.sv
// Holds an 8-bit word on the mux inputs and steps the 3-bit select, HOLD_CYCLES clocks per bit.
// Latency: bit_valid one clock after acceptance; backpressure: in_ready only in IDLE or on the done cycle.
// MUX8_SEQ_MSB_FIRST_EN selects a 7->0 select order instead of 0->7.
module mux8_sel_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux8_sel_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic [7:0]       mux_in_q;
    logic [2:0]       sel_q;
    logic [2:0]       sel_d;
    logic [CNT_W-1:0] dwell_q;

    logic shifting;
    logic dwell_end;
    logic last_bit;
    logic done_w;
    logic ready_w;
    logic accept;

`ifdef MUX8_SEQ_MSB_FIRST_EN
    localparam logic [2:0] START_IDX = 3'd7;
    localparam logic [2:0] END_IDX   = 3'd0;
    assign sel_d = sel_q - 3'd1;
`else
    localparam logic [2:0] START_IDX = 3'd0;
    localparam logic [2:0] END_IDX   = 3'd7;
    assign sel_d = sel_q + 3'd1;
`endif

    assign shifting  = (state_q == SHIFT);
    assign dwell_end = (dwell_q == DWELL_LAST);
    assign last_bit  = shifting && (sel_q == END_IDX);
    assign done_w    = last_bit && dwell_end;
    assign ready_w   = !shifting || done_w;
    assign accept    = bus.in_valid && ready_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mux_in_q <= 8'h00;
            sel_q    <= 3'd0;
            dwell_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mux_in_q <= bus.in_data;
                        sel_q    <= START_IDX;
                        dwell_q  <= '0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (dwell_end) begin
                        dwell_q <= '0;
                        // On the done cycle a waiting word restarts the sweep with no bubble;
                        // otherwise the select wraps back to the start index and we go idle.
                        if (done_w && accept) begin
                            mux_in_q <= bus.in_data;
                            sel_q    <= START_IDX;
                        end else begin
                            sel_q <= sel_d;
                            if (done_w) begin
                                state_q <= IDLE;
                            end
                        end
                    end else begin
                        dwell_q <= dwell_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ready_w;
    assign bus.mux_in    = mux_in_q;
    assign bus.mux_sel   = sel_q;
    assign bus.bit_valid = shifting;
    assign bus.bit_first = shifting && (sel_q == START_IDX);
    assign bus.bit_last  = last_bit;
    assign bus.done      = done_w;
endmodule

// File: tb/tb_mux8_sel_sequencer.sv
// Drives two sequencers (HOLD_CYCLES 1 and 3) with directed and random words against a word-level model.
module tb_mux8_sel_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    always #5 clk = ~clk;

    mux8_sel_sequencer_if b0();
    mux8_sel_sequencer_if b1();

    assign b0.in_valid = in_valid;
    assign b0.in_data  = in_data;
    assign b1.in_valid = in_valid;
    assign b1.in_data  = in_data;

    mux8_sel_sequencer #(.HOLD_CYCLES(1), .CNT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mux8_sel_sequencer #(.HOLD_CYCLES(3), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

`ifdef MUX8_SEQ_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif
    localparam logic [2:0] START = MSB ? 3'd7 : 3'd0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a word occupies 8*H cycles; k counts cycles elapsed within the word.
    int         hold[2] = '{1, 3};
    bit         busy[2];
    int         k[2];
    logic [7:0] word[2];
    logic [2:0] idle_sel[2];

    task automatic chk(string tag, int d, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_sel(int d);
        int bi;
        if (!busy[d]) return idle_sel[d];
        bi = k[d] / hold[d];
        return MSB ? 3'(7 - bi) : 3'(bi);
    endfunction

    function automatic bit exp_done(int d);
        return busy[d] && (k[d] == 8 * hold[d] - 1);
    endfunction

    function automatic bit exp_ready(int d);
        return !busy[d] || exp_done(d);
    endfunction

    task automatic check_dut(int d);
        logic [7:0] o_in;
        logic [2:0] o_sel;
        logic       o_rdy, o_bv, o_bf, o_bl, o_dn;
        logic [2:0] e_sel;
        logic [7:0] w;
        int         bi;
        if (d == 0) begin
            o_in = b0.mux_in; o_sel = b0.mux_sel; o_rdy = b0.in_ready; o_bv = b0.bit_valid;
            o_bf = b0.bit_first; o_bl = b0.bit_last; o_dn = b0.done;
        end else begin
            o_in = b1.mux_in; o_sel = b1.mux_sel; o_rdy = b1.in_ready; o_bv = b1.bit_valid;
            o_bf = b1.bit_first; o_bl = b1.bit_last; o_dn = b1.done;
        end
        e_sel = exp_sel(d);
        bi    = busy[d] ? k[d] / hold[d] : -1;
        w     = word[d];
        chk("in_ready",  d, 8'(o_rdy), 8'(exp_ready(d)));
        chk("mux_in",    d, o_in, w);
        chk("mux_sel",   d, 8'(o_sel), 8'(e_sel));
        chk("bit_valid", d, 8'(o_bv), 8'(busy[d]));
        chk("bit_first", d, 8'(o_bf), 8'(bi == 0));
        chk("bit_last",  d, 8'(o_bl), 8'(bi == 7));
        chk("done",      d, 8'(o_dn), 8'(exp_done(d)));
        if (busy[d]) chk("serial_bit", d, 8'(o_in[o_sel]), 8'(w[e_sel]));
    endtask

    task automatic cycle();
        bit acc[2];
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        for (int d = 0; d < 2; d++) acc[d] = !rst && in_valid && exp_ready(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                busy[d] = 1'b0; k[d] = 0; word[d] = 8'h00; idle_sel[d] = 3'd0;
            end else if (acc[d]) begin
                busy[d] = 1'b1; k[d] = 0; word[d] = in_data;
            end else if (busy[d]) begin
                if (k[d] == 8 * hold[d] - 1) begin
                    busy[d] = 1'b0; idle_sel[d] = START;
                end else begin
                    k[d]++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        bit found;
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; k[d] = 0; word[d] = 8'h00; idle_sel[d] = 3'd0;
        end

        // Reset held two cycles with a word offered; nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk); #1;
        cycle(); cycle();
        rst = 1'b0; in_valid = 1'b0;
        cycle(); cycle();

        // Single word A5.
        in_valid = 1'b1; in_data = 8'hA5;
        cycle();
        in_valid = 1'b0; in_data = 8'(($urandom));
        repeat (30) cycle();

        // Back-to-back 3C then FF with in_valid held.
        in_valid = 1'b1; in_data = 8'h3C;
        cycle();
        in_data = 8'hFF;
        repeat (15) cycle();
        in_valid = 1'b0;
        repeat (30) cycle();

        // Reset in the middle of a word while dut0 addresses select 4.
        in_valid = 1'b1; in_data = 8'(($urandom));
        cycle();
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (busy[0] && exp_sel(0) == 3'd4) found = 1'b1;
            else cycle();
        end
        chk("reach_sel4", 0, 8'(found), 8'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (30) cycle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            cycle();
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (30) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
